mdio_target: RTL
================

# mdio_target

Clause-22 MDIO management target (PHY-side responder) that decodes serial management frames on the shared MDIO line and turns them into single-word register accesses. It is the counterpart to the team's MDIO station-management master: it models or implements the managed device. It exposes a simple register-port handshake to a local register file.

## Interface

Parameters:
- PHY_ADDR, 5'd1: address this target answers to.
- PRE_LEN, 32: minimum consecutive sampled 1s before ST is accepted (1..32).

Ports:
- mdc  input  1  management clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- mdio  inout  1  bidirectional data; target drives only during read TA2/DATA, else `z`.
- reg_addr  output  5  REGAD of the current frame.
- reg_rd  output  1  one-mdc-cycle read strobe.
- reg_rdata  input  16  read data, sampled one cycle after reg_rd.
- reg_wr  output  1  one-mdc-cycle write strobe.
- reg_wdata  output  16  write data, valid while reg_wr is high and held until the next write.
- busy  output  1  high from accepted ST through frame end.
- frame_err  output  1  one-cycle pulse on a malformed frame.

## Operation

- mdio is sampled on every rising mdc edge. Drive changes are registered on the rising edge; the master samples them on the following rising edge.
- States and transitions:
  - IDLE: count consecutive 1s, saturating at 32; a sampled 0 resets the count.
    - Sampled 0 with count ≥ PRE_LEN → ST2.
    - Sampled 0 with count < PRE_LEN → stay in IDLE.
  - ST2: sampled 1 → OP. Otherwise pulse frame_err → IDLE.
  - OP: 2 bits.
    - 10 = read, 01 = write.
    - 00 or 11 → pulse frame_err → IDLE after the second bit.
  - PHYAD: 5 bits, MSB first. At the 5th bit, set `sel` = (PHYAD == PHY_ADDR).
  - REGAD: 5 bits, MSB first.
    - At the 5th bit: load reg_addr.
    - If read and sel: pulse reg_rd.
  - TA: 2 bits.
    - Read and sel: the first TA sample cycle loads shift register ← reg_rdata and enables drive of 0 (TA2). The second TA cycle drives shift[15].
    - Write, or not sel: TA bits are ignored.
  - DATA: 16 bits.
    - Read and sel: shift out MSB-first, one bit per cycle. mdio is released on the edge after D0 has been driven for one full cycle.
    - Write: shift in 16 bits. After the 16th sample, if sel: update reg_wdata and pulse reg_wr.
    - Not sel: consume the bits silently.
    - → IDLE with preamble count 0.
- A frame for another PHY address is fully tracked, so its DATA bits are never mistaken for a preamble or ST.
- The preamble count restarts from 0 after every frame. Back-to-back frames each need ≥ PRE_LEN 1s.
- busy is high in every state except IDLE.

## Timing

- Reset values: mdio `z` (oe=0), reg_addr 0, reg_rd 0, reg_rdata shift 0, reg_wr 0, reg_wdata 0, busy 0, frame_err 0, state IDLE, preamble count 0.
- Asynchronous reset mid-frame releases mdio immediately and produces no strobe.
- Read timeline: let edge k sample the last REGAD bit.
  - k: reg_rd high for k..k+1.
  - k+1: reg_rdata captured; mdio driven 0.
  - k+2: D15 driven; k+17: D0 driven.
  - k+18: mdio released.
- Write timeline: let edge w sample D0. reg_wr and reg_wdata update at w. reg_wr is high for exactly one mdc cycle.
- Counters: 5-bit bit counter per field, 6-bit saturating preamble counter. No overflow possible.

## Structure

- Shared package `mdio_pkg` holds:
  - ST code 2'b01; OP_READ 2'b10 and OP_WRITE 2'b01.
  - Field widths (PHYAD/REGAD 5, DATA 16, TA 2), default preamble length 32.
  - State encoding constants, reused by the master.
- No sub-module. The tristate is a single continuous assignment in this block.

## Test plan

- Write frame: 32×1, 01, 01, PHYAD=1, REGAD=5'h04, TA 10, DATA 16'hA5C3 → single reg_wr, reg_addr=4, reg_wdata=A5C3, no drive on mdio.
- Read frame: PHYAD=1, REGAD=5'h02, reg_rdata=16'h1234 → reg_rd one cycle, mdio `z` on TA1 then 0, then 0001_0010_0011_0100 MSB-first, then `z`.
- PHYAD=3 read and write → no strobes, mdio never driven. An immediately following valid frame with 32 preamble bits is accepted.
- Preamble of 31 ones then 01 10 … → ignored: busy stays 0, no strobes. The same frame with 32 ones is accepted.
- OP=11 → frame_err pulses once, back to IDLE, no strobe. A later valid write succeeds.
- rst_n low at DATA bit 8 of a read → mdio `z` immediately, all outputs at reset values, the next valid read is correct.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared MDIO definitions: frame codes, field widths and FSM state encoding,
// used by both the management target and the station-management master.
package mdio_pkg;

  // Start-of-frame and opcode values as they appear on the line
  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  // Field widths in bits
  localparam int W_OP    = 2;
  localparam int W_PHYAD = 5;
  localparam int W_REGAD = 5;
  localparam int W_TA    = 2;
  localparam int W_DATA  = 16;

  // Default number of preamble ones required before ST
  localparam int DEF_PRE_LEN = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ST2   = 3'd1,
    S_OP    = 3'd2,
    S_PHYAD = 3'd3,
    S_REGAD = 3'd4,
    S_TA    = 3'd5,
    S_DATA  = 3'd6
  } mdio_state_e;

  // Only read and write opcodes form a legal clause-22 frame
  function automatic logic op_is_valid(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/mdio_target_if.sv
// Register-port handshake between the MDIO target and a local register file.
interface mdio_target_if;
  import mdio_pkg::*;

  logic [W_REGAD-1:0] reg_addr;
  logic               reg_rd;
  logic [W_DATA-1:0]  reg_rdata;
  logic               reg_wr;
  logic [W_DATA-1:0]  reg_wdata;

  // MDIO target side: issues strobes, receives read data
  modport master (
    output reg_addr, reg_rd, reg_wr, reg_wdata,
    input  reg_rdata
  );

  // Register file side
  modport slave (
    input  reg_addr, reg_rd, reg_wr, reg_wdata,
    output reg_rdata
  );
endinterface

// File: rtl/mdio_target.sv
// Clause-22 MDIO target: decodes management frames sampled on rising mdc,
// turns them into single-word register strobes and drives read data back.
module mdio_target
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'd1,
  parameter int         PRE_LEN  = DEF_PRE_LEN
) (
  input  logic          mdc,
  input  logic          rst_n,
  inout  wire           mdio,
  mdio_target_if.master reg_if,
  output logic          busy,
  output logic          frame_err
);

  localparam logic [5:0] PRE_LEN_C = 6'(PRE_LEN);
  localparam logic [5:0] PRE_SAT   = 6'd32;
  localparam logic [4:0] OP_LAST   = 5'(W_OP - 1);
  localparam logic [4:0] PHY_LAST  = 5'(W_PHYAD - 1);
  localparam logic [4:0] REG_LAST  = 5'(W_REGAD - 1);
  localparam logic [4:0] TA_LAST   = 5'(W_TA - 1);
  localparam logic [4:0] DATA_LAST = 5'(W_DATA - 1);

  mdio_state_e r_state;
  mdio_state_e w_next;
  logic [4:0]  r_cnt;
  logic [5:0]  r_pre_cnt;
  logic        r_op_hi;
  logic        r_is_read;
  logic        r_sel;
  logic [3:0]  r_addr_sh;
  logic [4:0]  r_reg_addr;
  logic        r_rd;
  logic        r_wr;
  logic [15:0] r_wdata;
  logic [15:0] r_shift;
  logic        r_oe;
  logic        r_mdo;
  logic        r_err;
  logic        r_busy;

  logic w_mdi;
  logic w_drv;
  logic w_err;
  logic w_phy_last;
  logic w_reg_last;
  logic w_rd_go;
  logic w_ta_load;
  logic w_shift_out;
  logic w_shift_in;
  logic w_release;
  logic w_wr_go;

  assign w_mdi = mdio;
  // A read addressed to us is the only case where the target owns the line
  assign w_drv = r_is_read && r_sel;

  // Single tristate driver for the shared management line
  assign mdio = r_oe ? r_mdo : 1'bz;

  assign reg_if.reg_addr  = r_reg_addr;
  assign reg_if.reg_rd    = r_rd;
  assign reg_if.reg_wr    = r_wr;
  assign reg_if.reg_wdata = r_wdata;
  assign busy             = r_busy;
  assign frame_err        = r_err;

  // FSM state register
  always_ff @(posedge mdc or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state decode, one field at a time
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if ((w_mdi == ST_CODE[1]) && (r_pre_cnt >= PRE_LEN_C)) w_next = S_ST2;
        else                                                  w_next = S_IDLE;
      end
      S_ST2: begin
        if (w_mdi == ST_CODE[0]) w_next = S_OP;
        else                     w_next = S_IDLE;
      end
      S_OP: begin
        if (r_cnt != OP_LAST)                    w_next = S_OP;
        else if (op_is_valid({r_op_hi, w_mdi}))  w_next = S_PHYAD;
        else                                     w_next = S_IDLE;
      end
      S_PHYAD: begin
        if (r_cnt == PHY_LAST) w_next = S_REGAD;
        else                   w_next = S_PHYAD;
      end
      S_REGAD: begin
        if (r_cnt == REG_LAST) w_next = S_TA;
        else                   w_next = S_REGAD;
      end
      S_TA: begin
        if (r_cnt == TA_LAST) w_next = S_DATA;
        else                  w_next = S_TA;
      end
      S_DATA: begin
        if (r_cnt == DATA_LAST) w_next = S_IDLE;
        else                    w_next = S_DATA;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // FSM output decode: per-cycle datapath controls and strobe requests
  always_comb begin
    w_err       = 1'b0;
    w_phy_last  = 1'b0;
    w_reg_last  = 1'b0;
    w_rd_go     = 1'b0;
    w_ta_load   = 1'b0;
    w_shift_out = 1'b0;
    w_shift_in  = 1'b0;
    w_release   = 1'b0;
    w_wr_go     = 1'b0;
    case (r_state)
      S_IDLE: w_err = 1'b0;
      S_ST2: begin
        if (w_mdi != ST_CODE[0]) w_err = 1'b1;
        else                     w_err = 1'b0;
      end
      S_OP: begin
        if ((r_cnt == OP_LAST) && !op_is_valid({r_op_hi, w_mdi})) w_err = 1'b1;
        else                                                     w_err = 1'b0;
      end
      S_PHYAD: w_phy_last = (r_cnt == PHY_LAST);
      S_REGAD: begin
        w_reg_last = (r_cnt == REG_LAST);
        w_rd_go    = (r_cnt == REG_LAST) && w_drv;
      end
      S_TA: begin
        // First TA cycle grabs read data and starts driving 0; second puts out D15
        w_ta_load   = (r_cnt == 5'd0) && w_drv;
        w_shift_out = (r_cnt == TA_LAST) && w_drv;
      end
      S_DATA: begin
        w_release   = (r_cnt == DATA_LAST);
        w_shift_out = (r_cnt != DATA_LAST) && w_drv;
        w_shift_in  = !r_is_read;
        w_wr_go     = (r_cnt == DATA_LAST) && !r_is_read && r_sel;
      end
      default: w_err = 1'b0;
    endcase
  end

  // Field bit counter and saturating preamble counter
  always_ff @(posedge mdc or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 5'd0;
      r_pre_cnt <= 6'd0;
    end else begin
      if ((w_next != r_state) || (r_state == S_IDLE)) r_cnt <= 5'd0;
      else                                            r_cnt <= r_cnt + 5'd1;
      if (r_state != S_IDLE)          r_pre_cnt <= 6'd0;
      else if (!w_mdi)                r_pre_cnt <= 6'd0;
      else if (r_pre_cnt != PRE_SAT)  r_pre_cnt <= r_pre_cnt + 6'd1;
      else                            r_pre_cnt <= r_pre_cnt;
    end
  end

  // Frame header capture: opcode, address match and register address
  always_ff @(posedge mdc or negedge rst_n) begin
    if (!rst_n) begin
      r_op_hi    <= 1'b0;
      r_is_read  <= 1'b0;
      r_sel      <= 1'b0;
      r_addr_sh  <= 4'd0;
      r_reg_addr <= 5'd0;
    end else begin
      if ((r_state == S_OP) && (r_cnt == 5'd0)) r_op_hi <= w_mdi;
      if ((r_state == S_OP) && (r_cnt == OP_LAST)) r_is_read <= ({r_op_hi, w_mdi} == OP_READ);
      if ((r_state == S_PHYAD) || (r_state == S_REGAD)) r_addr_sh <= {r_addr_sh[2:0], w_mdi};
      if (w_phy_last) r_sel <= ({r_addr_sh, w_mdi} == PHY_ADDR);
      if (w_reg_last) r_reg_addr <= {r_addr_sh, w_mdi};
    end
  end

  // Data shift register, line driver and registered strobes
  always_ff @(posedge mdc or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= 16'd0;
      r_mdo   <= 1'b0;
      r_oe    <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_wdata <= 16'd0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_rd   <= w_rd_go;
      r_wr   <= w_wr_go;
      r_err  <= w_err;
      r_busy <= (w_next != S_IDLE);
      if (w_ta_load) begin
        r_shift <= reg_if.reg_rdata;
        r_mdo   <= 1'b0;
        r_oe    <= 1'b1;
      end else if (w_shift_out) begin
        r_shift <= {r_shift[14:0], 1'b0};
        r_mdo   <= r_shift[15];
      end else if (w_shift_in) begin
        r_shift <= {r_shift[14:0], w_mdi};
      end
      if (w_release) r_oe <= 1'b0;
      if (w_wr_go) r_wdata <= {r_shift[14:0], w_mdi};
    end
  end

endmodule
